// File: rtl/mux_console.sv
// mux_console: memory-mapped 8N1 serial console on the CPU system bus.
//   Two byte addresses starting at BASE_ADDR:
//     BASE+0  read STATUS {3'b0, fe, ovr, txIdle, txNotFull, rxReady};
//             write bit3 clears ovr, bit4 clears fe
//     BASE+1  read RX holding byte (readEnBus clears rxReady);
//             write pushes a byte into the TX FIFO
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   addressBus, dataOutBus  CPU address and write data
//   writeEnBus, readEnBus   CPU write strobe / read-sample strobe
//   dataInBus, selected     read data (zero when not decoded), decode hit
//   txd, rxd                serial out (idle high), serial in (asynchronous)
module mux_console #(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned TX_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    input  logic [7:0]  dataOutBus,
    input  logic        writeEnBus,
    input  logic        readEnBus,
    output logic [7:0]  dataInBus,
    output logic        selected,
    output logic        txd,
    input  logic        rxd
);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- address decode ----------------
    logic sel_stat, sel_data;
    assign sel_stat = (addressBus == BASE_ADDR);
    assign sel_data = (addressBus == BASE_ADDR + 16'd1);
    assign selected = sel_stat | sel_data;

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_q [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          tx_pop, push_ok, fifo_nonempty;

    assign fifo_nonempty = (count_q != '0);
    // A full FIFO still accepts a push when the shifter pops in the same cycle.
    assign push_ok = writeEnBus && sel_data && ((count_q < DEPTH_C) || tx_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, tx_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_q[wr_ptr_q] <= dataOutBus;
    end

    // ---------------- TX FSM ----------------
    state_t        tx_state_q, tx_state_d;
    logic [TW-1:0] tx_tmr_q, tx_tmr_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tmr_d   = tx_tmr_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (fifo_nonempty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_q[rd_ptr_q];
                    tx_tmr_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_tmr_q == T_LAST) begin
                    tx_tmr_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_tmr_d = tx_tmr_q + TW'(1);
                end
            end
            S_DATA: begin
                if (tx_tmr_q == T_LAST) begin
                    tx_tmr_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_tmr_d = tx_tmr_q + TW'(1);
                end
            end
            default: begin // S_STOP
                if (tx_tmr_q == T_LAST) begin
                    tx_tmr_d = '0;
                    // Chain straight into the next start bit so frames are gapless.
                    if (fifo_nonempty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_q[rd_ptr_q];
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_tmr_d = tx_tmr_q + TW'(1);
                end
            end
        endcase
    end

    always_comb begin
        case (tx_state_q)
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    // ---------------- RX synchroniser ----------------
    // s1/s2 form the synchroniser; s3 is s2 delayed, used only for edge detect.
    logic rx_s1_q, rx_s2_q, rx_s3_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // ---------------- RX FSM ----------------
    state_t        rx_state_q, rx_state_d;
    logic [TW-1:0] rx_tmr_q, rx_tmr_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_stop_sample;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_tmr_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tmr_q   <= rx_tmr_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_tmr_d       = rx_tmr_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_stop_sample = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_tmr_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                // Mid start bit: the timer restarts here so later samples land mid-bit.
                if (rx_tmr_q == T_HALF) begin
                    rx_tmr_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_tmr_d = rx_tmr_q + TW'(1);
                end
            end
            S_DATA: begin
                if (rx_tmr_q == T_LAST) begin
                    rx_tmr_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_tmr_d = rx_tmr_q + TW'(1);
                end
            end
            default: begin // S_STOP
                if (rx_tmr_q == T_LAST) begin
                    rx_tmr_d       = '0;
                    rx_stop_sample = 1'b1;
                    rx_state_d     = S_IDLE;
                end else begin
                    rx_tmr_d = rx_tmr_q + TW'(1);
                end
            end
        endcase
    end

    // ---------------- RX holding and status flags ----------------
    logic [7:0] rx_hold_q;
    logic       rx_ready_q, ovr_q, fe_q;
    logic       rd_clear, rx_load, stat_wr;

    assign rd_clear = readEnBus && sel_data;
    assign stat_wr  = writeEnBus && sel_stat;
    // A read consuming the old byte in the same cycle frees the holding register.
    assign rx_load  = rx_stop_sample && rx_s2_q && (!rx_ready_q || rd_clear);

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_hold_q  <= '0;
            rx_ready_q <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_hold_q  <= rx_shift_q;
                rx_ready_q <= 1'b1;
            end else if (rd_clear) begin
                rx_ready_q <= 1'b0;
            end
            // Clears come first so a same-cycle set wins.
            if (stat_wr && dataOutBus[3]) ovr_q <= 1'b0;
            if (stat_wr && dataOutBus[4]) fe_q  <= 1'b0;
            if (rx_stop_sample && rx_s2_q && !rx_load) ovr_q <= 1'b1;
            if (rx_stop_sample && !rx_s2_q)            fe_q  <= 1'b1;
        end
    end

    // ---------------- read mux ----------------
    logic [7:0] status;
    logic       tx_idle, tx_not_full;

    assign tx_idle     = (tx_state_q == S_IDLE) && !fifo_nonempty;
    assign tx_not_full = (count_q < DEPTH_C);
    assign status      = {3'b000, fe_q, ovr_q, tx_idle, tx_not_full, rx_ready_q};

    always_comb begin
        dataInBus = 8'h00;
        if (sel_stat)      dataInBus = status;
        else if (sel_data) dataInBus = rx_hold_q;
    end
endmodule

// File: tb/tb_mux_console.sv
// tb_mux_console: directed self-checking bench for mux_console.
// All tasks start and end on a falling clock edge; inputs change there and
// outputs are sampled there, away from the rising edge.
module tb_mux_console;
    localparam logic [15:0] BASE = 16'hF200;

    logic        clock;
    logic        reset;
    logic [15:0] addressBus;
    logic [7:0]  dataOutBus;
    logic        writeEnBus;
    logic        readEnBus;
    logic [7:0]  dataInBus;
    logic        selected;
    logic        txd;
    logic        rxd;

    int n_checks = 0;
    int n_fail   = 0;

    mux_console dut (
        .clock      (clock),
        .reset      (reset),
        .addressBus (addressBus),
        .dataOutBus (dataOutBus),
        .writeEnBus (writeEnBus),
        .readEnBus  (readEnBus),
        .dataInBus  (dataInBus),
        .selected   (selected),
        .txd        (txd),
        .rxd        (rxd)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- bus / line helpers ----------------
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addressBus = a;
        dataOutBus = d;
        writeEnBus = 1'b1;
        @(negedge clock);
        writeEnBus = 1'b0;
        addressBus = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        addressBus = a;
        readEnBus  = 1'b1;
        #1 d = dataInBus;
        @(negedge clock);
        readEnBus  = 1'b0;
        addressBus = 16'h0000;
    endtask

    task automatic peek(input logic [15:0] a, output logic [7:0] d);
        addressBus = a;
        #1 d = dataInBus;
    endtask

    // Start bit plus 8 data bits, 16 clocks each.
    task automatic rx_start_data(input logic [7:0] b);
        rxd = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clock);
        end
    endtask

    task automatic rx_stop(input logic s);
        rxd = s;
        repeat (16) @(negedge clock);
        rxd = 1'b1;
    endtask

    // Called at mid start bit; returns at mid stop bit. f[0] is the start bit.
    task automatic collect_tx(output logic [9:0] f);
        for (int j = 0; j < 10; j++) begin
            f[j] = txd;
            if (j < 9) repeat (16) @(negedge clock);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [7:0] d;
        reset = 1'b1; addressBus = 16'h0000; dataOutBus = 8'h00;
        writeEnBus = 1'b0; readEnBus = 1'b0; rxd = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL reset_status got %h want 06", d); end
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd); end
        n_checks++;
        if (selected !== 1'b1) begin n_fail++; $display("FAIL sel_base got %b want 1", selected); end
        peek(16'h1000, d);
        n_checks++;
        if (d !== 8'h00 || selected !== 1'b0) begin
            n_fail++; $display("FAIL unsel_read got %h/%b want 00/0", d, selected);
        end
        peek(BASE + 16'd2, d);
        n_checks++;
        if (selected !== 1'b0) begin n_fail++; $display("FAIL sel_base2 got %b want 0", selected); end
        // A write to an unselected address must not start the transmitter.
        @(negedge clock);
        bus_write(BASE + 16'd2, 8'hFF);
        repeat (4) @(negedge clock);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06 || txd !== 1'b1) begin
            n_fail++; $display("FAIL unsel_write status %h txd %b want 06/1", d, txd);
        end
        $display("test_reset done");
    endtask

    task automatic test_tx_single;
        logic [7:0] d;
        logic [9:0] f;
        bus_write(BASE + 16'd1, 8'hA5);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_pre_start got %b want 1", txd); end
        @(negedge clock);
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL tx_start_edge got %b want 0", txd); end
        repeat (8) @(negedge clock);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL tx_busy_status got %h want 02", d); end
        collect_tx(f);
        n_checks++;
        if (f !== {1'b1, 8'hA5, 1'b0}) begin
            n_fail++; $display("FAIL tx_frame_A5 got %b want %b", f, {1'b1, 8'hA5, 1'b0});
        end
        repeat (9) @(negedge clock);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL tx_idle_after got %h want 06", d); end
        $display("test_tx_single done frame=%b", f);
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic [9:0] f;
        logic [7:0] bytes [6];
        int         lows;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        for (int i = 0; i < 6; i++) bus_write(BASE + 16'd1, bytes[i]);
        // First byte is shifting, four queued, sixth dropped: full and busy.
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL fifo_full_status got %h want 00", d); end
        repeat (4) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            collect_tx(f);
            n_checks++;
            if (f !== {1'b1, bytes[k], 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_frame%0d got %b want %b", k, f, {1'b1, bytes[k], 1'b0});
            end
            $display("b2b frame %0d = %b", k, f);
            if (k < 4) repeat (16) @(negedge clock);
        end
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin n_fail++; $display("FAIL dropped_6th low_cycles %0d want 0", lows); end
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL b2b_idle got %h want 06", d); end
        $display("test_back_to_back done");
    endtask

    task automatic test_rx_frame;
        logic [7:0] d;
        rx_start_data(8'h3C);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL rx_early_status got %h want 06", d); end
        rx_stop(1'b1);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h07) begin n_fail++; $display("FAIL rx_ready_status got %h want 07", d); end
        bus_read(BASE + 16'd1, d);
        n_checks++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL rx_data got %h want 3c", d); end
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL rx_ready_clear got %h want 06", d); end
        $display("test_rx_frame done");
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        rx_start_data(8'h5A); rx_stop(1'b1);
        rx_start_data(8'hC3); rx_stop(1'b1);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h0F) begin n_fail++; $display("FAIL ovr_status got %h want 0f", d); end
        peek(BASE + 16'd1, d);
        n_checks++;
        if (d !== 8'h5A) begin n_fail++; $display("FAIL ovr_hold got %h want 5a", d); end
        @(negedge clock);
        bus_write(BASE, 8'h08);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h07) begin n_fail++; $display("FAIL ovr_clear got %h want 07", d); end
        bus_read(BASE + 16'd1, d);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL ovr_read_clear got %h want 06", d); end
        $display("test_overrun done");
    endtask

    task automatic test_framing_glitch;
        logic [7:0] d;
        rx_start_data(8'h81); rx_stop(1'b0);
        repeat (2) @(negedge clock);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h16) begin n_fail++; $display("FAIL fe_status got %h want 16", d); end
        @(negedge clock);
        bus_write(BASE, 8'h10);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL fe_clear got %h want 06", d); end
        @(negedge clock);
        rxd = 1'b0;
        repeat (4) @(negedge clock);
        rxd = 1'b1;
        repeat (200) @(negedge clock);
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL glitch_status got %h want 06", d); end
        peek(BASE + 16'd1, d);
        n_checks++;
        if (d !== 8'h5A) begin n_fail++; $display("FAIL glitch_hold got %h want 5a", d); end
        $display("test_framing_glitch done");
    endtask

    task automatic test_reset_mid_tx;
        logic [7:0] d;
        int         lows;
        @(negedge clock);
        for (int i = 0; i < 4; i++) bus_write(BASE + 16'd1, 8'h00);
        repeat (38) @(negedge clock);
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL mid_tx_low got %b want 0", txd); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd_mid got %b want 1", txd); end
        peek(BASE, d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL reset_status_mid got %h want 06", d); end
        reset = 1'b0;
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin n_fail++; $display("FAIL fifo_lost low_cycles %0d want 0", lows); end
        $display("test_reset_mid_tx done");
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_frame();
        test_overrun();
        test_framing_glitch();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
